// File: rtl/pic_ctl_sched.sv
// pic_ctl_sched: merges UART image-select requests and the slideshow timer
// into one valid/ready command stream for the frame controller.
// UART has strict priority; the timer only counts while the controller waits.
//
// state   | meaning
// S_IDLE  | nothing on offer, pick UART hold register first, then slideshow
// S_OFFER | command on offer, payload frozen until ctl_ready accepts it
module pic_ctl_sched #(
  parameter int TICK_DIV = 4000,
  parameter int SLIDE_MS = 5000
) (
  input  logic clk_4M,
  input  logic rst,
  input  logic uart_incr,
  input  logic uart_decr,
  input  logic uart_valid,
  output logic uart_ready,
  input  logic auto_en,
  input  logic auto_dir,
  output logic ctl_incr,
  output logic ctl_decr,
  output logic ctl_valid,
  input  logic ctl_ready,
  output logic cmd_src,
  output logic cmd_drop
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   MS_LAST    = 16'(SLIDE_MS - 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t state, state_nxt;
  logic valid_nxt, incr_nxt, decr_nxt, src_nxt;

  logic hold_full, hold_incr, hold_decr;
  logic auto_pend;
  logic [PW-1:0] presc;
  logic [15:0]   ms_cnt;

  logic accept, legal, xfer, run, tick, expire, auto_on_offer;

  assign uart_ready    = ~hold_full;
  assign accept        = uart_valid & ~hold_full;
  assign legal         = uart_incr ^ uart_decr;
  assign xfer          = ctl_valid & ctl_ready;
  assign run           = auto_en & ctl_ready & ~auto_pend;
  assign tick          = run & (presc == PRESC_LAST);
  assign expire        = tick & (ms_cnt == MS_LAST);
  assign auto_on_offer = ctl_valid & cmd_src;

  // UART holding register and illegal-request drop pulse
  always_ff @(posedge clk_4M) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_incr <= 1'b0;
      hold_decr <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      if (xfer & ~cmd_src) begin
        hold_full <= 1'b0;
      end else if (accept & legal) begin
        hold_full <= 1'b1;
        hold_incr <= uart_incr;
        hold_decr <= uart_decr;
      end
      cmd_drop <= accept & ~legal;
    end
  end

  // display-time prescaler and ms counter, restarted whenever the controller is busy
  always_ff @(posedge clk_4M) begin
    if (rst || xfer || !run) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (tick) begin
      presc  <= '0;
      ms_cnt <= (ms_cnt == MS_LAST) ? 16'd0 : ms_cnt + 16'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // slideshow pending flag; a slideshow command already on offer survives auto_en falling
  always_ff @(posedge clk_4M) begin
    if (rst) begin
      auto_pend <= 1'b0;
    end else if (expire) begin
      auto_pend <= 1'b1;
    end else if (xfer & cmd_src) begin
      auto_pend <= 1'b0;
    end else if (~auto_en & ~auto_on_offer) begin
      auto_pend <= 1'b0;
    end
  end

  // FSM state and registered command outputs
  always_ff @(posedge clk_4M) begin
    if (rst) begin
      state     <= S_IDLE;
      ctl_valid <= 1'b0;
      ctl_incr  <= 1'b0;
      ctl_decr  <= 1'b0;
      cmd_src   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ctl_valid <= valid_nxt;
      ctl_incr  <= incr_nxt;
      ctl_decr  <= decr_nxt;
      cmd_src   <= src_nxt;
    end
  end

  // next-state and next-output selection, UART before slideshow
  always_comb begin
    state_nxt = state;
    valid_nxt = ctl_valid;
    incr_nxt  = ctl_incr;
    decr_nxt  = ctl_decr;
    src_nxt   = cmd_src;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          valid_nxt = 1'b1;
          incr_nxt  = hold_incr;
          decr_nxt  = hold_decr;
          src_nxt   = 1'b0;
          state_nxt = S_OFFER;
        end else if (auto_pend) begin
          valid_nxt = 1'b1;
          incr_nxt  = ~auto_dir;
          decr_nxt  = auto_dir;
          src_nxt   = 1'b1;
          state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (xfer) begin
          valid_nxt = 1'b0;
          incr_nxt  = 1'b0;
          decr_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pic_ctl_sched.sv
// Testbench for pic_ctl_sched: vector table for UART intake/offer behaviour,
// hand-written sequences for slideshow timing, priority and back-pressure.
module tb_pic_ctl_sched;

  logic clk_4M = 1'b0;
  logic rst, uart_incr, uart_decr, uart_valid, uart_ready;
  logic auto_en, auto_dir, ctl_incr, ctl_decr, ctl_valid, ctl_ready, cmd_src, cmd_drop;

  int checks = 0;
  int errors = 0;

  pic_ctl_sched #(.TICK_DIV(4), .SLIDE_MS(3)) dut (
    .clk_4M(clk_4M), .rst(rst),
    .uart_incr(uart_incr), .uart_decr(uart_decr), .uart_valid(uart_valid), .uart_ready(uart_ready),
    .auto_en(auto_en), .auto_dir(auto_dir),
    .ctl_incr(ctl_incr), .ctl_decr(ctl_decr), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
    .cmd_src(cmd_src), .cmd_drop(cmd_drop)
  );

  always #5 clk_4M = ~clk_4M;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // inputs {uart_incr, uart_decr, uart_valid, ctl_ready}
  // expected {ctl_valid, ctl_incr, ctl_decr, cmd_src, cmd_drop, uart_ready} after the edge
  typedef struct {
    logic [3:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [26];

  task automatic step();
    @(posedge clk_4M);
    @(negedge clk_4M);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {ctl_valid, ctl_incr, ctl_decr, cmd_src, cmd_drop, uart_ready};
  endfunction

  task automatic uart(input logic i, input logic d, input logic v);
    uart_incr  = i;
    uart_decr  = d;
    uart_valid = v;
  endtask

  // steps until ctl_valid rises; returns the number of edges, or -1 on timeout
  task automatic wait_offer(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ctl_valid) begin
        n = k;
        break;
      end
    end
  endtask

  int n;
  int rises;

  initial begin
    vecs = '{
      '{4'b1010, 6'b000000}, '{4'b0000, 6'b110000}, '{4'b0000, 6'b110000},
      '{4'b0000, 6'b110000}, '{4'b0000, 6'b110000}, '{4'b0000, 6'b110000},
      '{4'b0000, 6'b110000}, '{4'b0000, 6'b110000}, '{4'b0000, 6'b110000},
      '{4'b0000, 6'b110000}, '{4'b0001, 6'b000001}, '{4'b0001, 6'b000001},
      '{4'b1111, 6'b000011}, '{4'b0001, 6'b000001}, '{4'b0011, 6'b000011},
      '{4'b0001, 6'b000001}, '{4'b0111, 6'b000000}, '{4'b0001, 6'b101000},
      '{4'b0001, 6'b000001}, '{4'b1010, 6'b000000}, '{4'b0110, 6'b110000},
      '{4'b0110, 6'b110000}, '{4'b0111, 6'b000001}, '{4'b0111, 6'b000000},
      '{4'b0000, 6'b101000}, '{4'b0001, 6'b000001}
    };

    // reset held two cycles with a UART request present
    rst = 1'b1; uart(1'b1, 1'b0, 1'b1);
    auto_en = 1'b0; auto_dir = 1'b0; ctl_ready = 1'b0;
    @(negedge clk_4M);
    step();
    step();
    chk("reset_outs", outs(), 6'b000001);
    rst = 1'b0; uart(1'b0, 1'b0, 1'b0);
    step();
    chk("after_reset_outs", outs(), 6'b000001);

    // UART intake, offer hold, drops and back-pressure
    for (int i = 0; i < 26; i++) begin
      uart(vecs[i].in[3], vecs[i].in[2], vecs[i].in[1]);
      ctl_ready = vecs[i].in[0];
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    uart(1'b0, 1'b0, 1'b0);

    // slideshow interval: offer 13 edges after the timer starts
    auto_en = 1'b1; auto_dir = 1'b1; ctl_ready = 1'b1;
    wait_offer(n);
    chk("slide_latency", n, 13);
    chk("slide_payload", {ctl_incr, ctl_decr, cmd_src}, 3'b011);
    step();
    chk("slide_xfer", ctl_valid, 1'b0);
    auto_en = 1'b0;
    step();

    // ctl_ready drop at cycle 8 restarts the full interval
    auto_en = 1'b1; ctl_ready = 1'b1;
    repeat (7) step();
    ctl_ready = 1'b0;
    step();
    step();
    chk("restart_no_offer", ctl_valid, 1'b0);
    ctl_ready = 1'b1;
    wait_offer(n);
    chk("restart_latency", n, 13);
    step();
    auto_en = 1'b0;
    step();
    chk("restart_xfer", ctl_valid, 1'b0);

    // UART and auto_pend on the same edge: UART first, slideshow after one idle cycle
    auto_en = 1'b1; auto_dir = 1'b0; ctl_ready = 1'b1;
    repeat (11) step();
    chk("prio_quiet", ctl_valid, 1'b0);
    uart(1'b0, 1'b1, 1'b1);
    step();
    uart(1'b0, 1'b0, 1'b0);
    chk("prio_accept", {ctl_valid, uart_ready}, 2'b00);
    step();
    chk("prio_uart_offer", {ctl_valid, ctl_incr, ctl_decr, cmd_src}, 4'b1010);
    step();
    chk("prio_gap", ctl_valid, 1'b0);
    step();
    chk("prio_slide_offer", {ctl_valid, ctl_incr, ctl_decr, cmd_src}, 4'b1101);
    step();
    auto_en = 1'b0;
    chk("prio_slide_xfer", ctl_valid, 1'b0);
    step();

    // auto_en dropped while slideshow pends behind a UART offer
    auto_en = 1'b1; auto_dir = 1'b1; ctl_ready = 1'b1;
    repeat (11) step();
    uart(1'b1, 1'b0, 1'b1);
    step();
    uart(1'b0, 1'b0, 1'b0);
    ctl_ready = 1'b0;
    step();
    auto_en = 1'b0;
    step();
    chk("cancel_uart_held", {ctl_valid, ctl_incr, cmd_src}, 3'b110);
    ctl_ready = 1'b1;
    step();
    chk("cancel_uart_xfer", ctl_valid, 1'b0);
    rises = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ctl_valid) rises++;
    end
    chk("cancel_no_slide", rises, 0);

    // slideshow offer back-pressured, auto_en falls, two UART requests arrive
    auto_en = 1'b1; auto_dir = 1'b1; ctl_ready = 1'b1;
    repeat (12) step();
    ctl_ready = 1'b0;
    step();
    chk("bp_slide_offer", {ctl_valid, ctl_decr, cmd_src}, 3'b111);
    auto_en = 1'b0;
    uart(1'b1, 1'b0, 1'b1);
    step();
    chk("bp_first_latched", {ctl_valid, ctl_decr, cmd_src, uart_ready}, 4'b1110);
    uart(1'b0, 1'b1, 1'b1);
    repeat (3) step();
    chk("bp_second_waits", {ctl_valid, cmd_src, uart_ready}, 3'b110);
    ctl_ready = 1'b1;
    step();
    chk("bp_slide_xfer", {ctl_valid, uart_ready}, 2'b00);
    step();
    chk("bp_first_offer", {ctl_valid, ctl_incr, ctl_decr, cmd_src, uart_ready}, 5'b11000);
    step();
    chk("bp_first_xfer", {ctl_valid, uart_ready}, 2'b01);
    step();
    uart(1'b0, 1'b0, 1'b0);
    chk("bp_second_accept", {ctl_valid, uart_ready}, 2'b00);
    step();
    chk("bp_second_offer", {ctl_valid, ctl_incr, ctl_decr, cmd_src}, 4'b1010);
    step();
    chk("bp_second_xfer", {ctl_valid, uart_ready}, 2'b01);

    // reset in the middle of an offer discards it
    ctl_ready = 1'b0;
    uart(1'b1, 1'b0, 1'b1);
    step();
    uart(1'b0, 1'b0, 1'b0);
    step();
    chk("rst_pre_offer", ctl_valid, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid_offer", outs(), 6'b000001);
    rst = 1'b0;
    step();
    chk("rst_after_offer", outs(), 6'b000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
